// File: rtl/uart_core.sv
// UART transmitter/receiver sharing one oversampling baud tick generator.
// Optional even-parity bit in both directions when UART_PARITY_EN is defined.
//
// state    | meaning (same encoding for the TX and RX FSMs)
// S_IDLE   | line idle; TX ready for a word, RX waiting for a falling edge
// S_START  | start bit (RX: waiting for mid-bit confirmation)
// S_DATA   | data bits, LSB first
// S_PARITY | even-parity bit (UART_PARITY_EN builds only)
// S_STOP   | stop bit(s); frame completes at the end of this state
module uart_core #(
  parameter int NB_DATA    = 8,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [DIV_W-1:0]   i_baud_div,
  input  logic               i_rx,
  input  logic [NB_DATA-1:0] i_tx_data,
  input  logic               i_tx_valid,
  output logic               o_tx_ready,
  output logic               o_tx,
  output logic               o_tx_done_tick,
  output logic [NB_DATA-1:0] o_rx_data,
  output logic               o_rx_done_tick,
  output logic               o_frame_err,
  output logic               o_parity_err
);

  localparam int TCW = $clog2(2 * OVERSAMPLE);
  localparam logic [TCW-1:0] OS_M1   = TCW'(OVERSAMPLE - 1);
  localparam logic [TCW-1:0] HALF_M1 = TCW'(OVERSAMPLE / 2 - 1);
  localparam logic [TCW-1:0] STOP_M1 = TCW'(STOP_BITS * OVERSAMPLE - 1);
  localparam logic [3:0]     LAST_BIT = 4'(NB_DATA - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  // Divisor is captured at each wrap so a change never truncates a tick period.
  logic [DIV_W-1:0] cnt_q, cnt_d, div_q, div_d;
  logic             tick;

  always_comb begin
    tick  = (cnt_q == div_q);
    cnt_d = tick ? '0 : cnt_q + DIV_W'(1);
    div_d = tick ? i_baud_div : div_q;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      cnt_q <= '0;
      div_q <= i_baud_div;
    end else begin
      cnt_q <= cnt_d;
      div_q <= div_d;
    end
  end

  state_t               tx_state_q, tx_state_d;
  logic [NB_DATA-1:0]   tx_sh_q, tx_sh_d;
  logic [TCW-1:0]       tx_tcnt_q, tx_tcnt_d;
  logic [3:0]           tx_bit_q, tx_bit_d;
  logic                 tx_q, tx_d, tx_ready_q, tx_ready_d, tx_done_q, tx_done_d;
`ifdef UART_PARITY_EN
  logic                 tx_par_q, tx_par_d;
`endif

  always_comb begin
    tx_state_d = tx_state_q;
    tx_sh_d    = tx_sh_q;
    tx_tcnt_d  = tx_tcnt_q;
    tx_bit_d   = tx_bit_q;
    tx_d       = tx_q;
    tx_done_d  = 1'b0;
`ifdef UART_PARITY_EN
    tx_par_d   = tx_par_q;
`endif
    case (tx_state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (i_tx_valid) begin
          tx_sh_d    = i_tx_data;
`ifdef UART_PARITY_EN
          tx_par_d   = ^i_tx_data;
`endif
          tx_tcnt_d  = OS_M1;
          tx_state_d = S_START;
          tx_d       = 1'b0;
        end
      end
      S_START: if (tick) begin
        if (tx_tcnt_q == '0) begin
          tx_state_d = S_DATA;
          tx_tcnt_d  = OS_M1;
          tx_bit_d   = '0;
          tx_d       = tx_sh_q[0];
        end else begin
          tx_tcnt_d = tx_tcnt_q - TCW'(1);
        end
      end
      S_DATA: if (tick) begin
        if (tx_tcnt_q == '0) begin
          tx_tcnt_d = OS_M1;
          if (tx_bit_q == LAST_BIT) begin
`ifdef UART_PARITY_EN
            tx_state_d = S_PARITY;
            tx_d       = tx_par_q;
`else
            tx_state_d = S_STOP;
            tx_tcnt_d  = STOP_M1;
            tx_d       = 1'b1;
`endif
          end else begin
            tx_bit_d = tx_bit_q + 4'd1;
            tx_sh_d  = tx_sh_q >> 1;
            tx_d     = tx_sh_q[1];
          end
        end else begin
          tx_tcnt_d = tx_tcnt_q - TCW'(1);
        end
      end
      S_PARITY: begin
`ifdef UART_PARITY_EN
        if (tick) begin
          if (tx_tcnt_q == '0) begin
            tx_state_d = S_STOP;
            tx_tcnt_d  = STOP_M1;
            tx_d       = 1'b1;
          end else begin
            tx_tcnt_d = tx_tcnt_q - TCW'(1);
          end
        end
`else
        tx_state_d = S_IDLE;
`endif
      end
      S_STOP: if (tick) begin
        if (tx_tcnt_q == '0) begin
          tx_state_d = S_IDLE;
          tx_done_d  = 1'b1;
          tx_d       = 1'b1;
        end else begin
          tx_tcnt_d = tx_tcnt_q - TCW'(1);
        end
      end
      default: tx_state_d = S_IDLE;
    endcase
    tx_ready_d = (tx_state_d == S_IDLE);
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      tx_state_q <= S_IDLE;
      tx_sh_q    <= '0;
      tx_tcnt_q  <= '0;
      tx_bit_q   <= '0;
      tx_q       <= 1'b1;
      tx_ready_q <= 1'b1;
      tx_done_q  <= 1'b0;
`ifdef UART_PARITY_EN
      tx_par_q   <= 1'b0;
`endif
    end else begin
      tx_state_q <= tx_state_d;
      tx_sh_q    <= tx_sh_d;
      tx_tcnt_q  <= tx_tcnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_q       <= tx_d;
      tx_ready_q <= tx_ready_d;
      tx_done_q  <= tx_done_d;
`ifdef UART_PARITY_EN
      tx_par_q   <= tx_par_d;
`endif
    end
  end

  assign o_tx           = tx_q;
  assign o_tx_ready     = tx_ready_q;
  assign o_tx_done_tick = tx_done_q;

  logic                 rx_s1_q, rx_s2_q;
  state_t               rx_state_q, rx_state_d;
  logic [NB_DATA-1:0]   rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
  logic [TCW-1:0]       rx_tcnt_q, rx_tcnt_d;
  logic [3:0]           rx_bit_q, rx_bit_d;
  logic                 rx_done_q, rx_done_d, ferr_q, ferr_d;
`ifdef UART_PARITY_EN
  logic                 rx_par_q, rx_par_d, perr_q, perr_d;
`endif

  always_comb begin
    rx_state_d = rx_state_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    rx_tcnt_d  = rx_tcnt_q;
    rx_bit_d   = rx_bit_q;
    rx_done_d  = 1'b0;
    ferr_d     = ferr_q;
`ifdef UART_PARITY_EN
    rx_par_d   = rx_par_q;
    perr_d     = perr_q;
`endif
    case (rx_state_q)
      S_IDLE: if (!rx_s2_q) begin
        rx_state_d = S_START;
        rx_tcnt_d  = HALF_M1;
      end
      S_START: if (tick) begin
        if (rx_tcnt_q == '0) begin
          // A start bit that is high again at mid-bit was only a glitch.
          rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
          rx_tcnt_d  = OS_M1;
          rx_bit_d   = '0;
        end else begin
          rx_tcnt_d = rx_tcnt_q - TCW'(1);
        end
      end
      S_DATA: if (tick) begin
        if (rx_tcnt_q == '0) begin
          rx_tcnt_d = OS_M1;
          rx_sh_d   = {rx_s2_q, rx_sh_q[NB_DATA-1:1]};
          if (rx_bit_q == LAST_BIT) begin
`ifdef UART_PARITY_EN
            rx_state_d = S_PARITY;
`else
            rx_state_d = S_STOP;
`endif
          end else begin
            rx_bit_d = rx_bit_q + 4'd1;
          end
        end else begin
          rx_tcnt_d = rx_tcnt_q - TCW'(1);
        end
      end
      S_PARITY: begin
`ifdef UART_PARITY_EN
        if (tick) begin
          if (rx_tcnt_q == '0) begin
            rx_par_d   = rx_s2_q;
            rx_state_d = S_STOP;
            rx_tcnt_d  = OS_M1;
          end else begin
            rx_tcnt_d = rx_tcnt_q - TCW'(1);
          end
        end
`else
        rx_state_d = S_IDLE;
`endif
      end
      S_STOP: if (tick) begin
        if (rx_tcnt_q == '0) begin
          rx_state_d = S_IDLE;
          rx_done_d  = 1'b1;
          rx_data_d  = rx_sh_q;
          ferr_d     = !rx_s2_q;
`ifdef UART_PARITY_EN
          perr_d     = rx_par_q ^ (^rx_sh_q);
`endif
        end else begin
          rx_tcnt_d = rx_tcnt_q - TCW'(1);
        end
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_state_q <= S_IDLE;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_tcnt_q  <= '0;
      rx_bit_q   <= '0;
      rx_done_q  <= 1'b0;
      ferr_q     <= 1'b0;
`ifdef UART_PARITY_EN
      rx_par_q   <= 1'b0;
      perr_q     <= 1'b0;
`endif
    end else begin
      rx_s1_q    <= i_rx;
      rx_s2_q    <= rx_s1_q;
      rx_state_q <= rx_state_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      rx_tcnt_q  <= rx_tcnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_done_q  <= rx_done_d;
      ferr_q     <= ferr_d;
`ifdef UART_PARITY_EN
      rx_par_q   <= rx_par_d;
      perr_q     <= perr_d;
`endif
    end
  end

  assign o_rx_data      = rx_data_q;
  assign o_rx_done_tick = rx_done_q;
  assign o_frame_err    = ferr_q;
`ifdef UART_PARITY_EN
  assign o_parity_err   = perr_q;
`else
  assign o_parity_err   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_core.sv
// Self-checking bench for uart_core: TX waveform, RX vector table, glitch,
// loopback (directed and random) and reset-abort sequences.
module tb_uart_core;
  localparam int NB = 8;
  localparam int OS = 16;
  localparam int STOPB = 1;
`ifdef UART_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] baud_div = 16'd3;
  logic        rx_drv = 1'b1;
  logic        loop_en = 1'b0;
  logic        rx_line;
  logic [7:0]  tx_data = 8'h00;
  logic        tx_valid = 1'b0;
  logic        tx_ready, tx, tx_done, rx_done, ferr, perr;
  logic [7:0]  rx_data;

  assign rx_line = loop_en ? tx : rx_drv;
  always #5 clk = ~clk;

  uart_core dut (
    .i_clock(clk), .i_reset(rst), .i_baud_div(baud_div), .i_rx(rx_line),
    .i_tx_data(tx_data), .i_tx_valid(tx_valid), .o_tx_ready(tx_ready),
    .o_tx(tx), .o_tx_done_tick(tx_done), .o_rx_data(rx_data),
    .o_rx_done_tick(rx_done), .o_frame_err(ferr), .o_parity_err(perr)
  );

  typedef struct {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } rx_rec_t;

  typedef struct {
    logic [7:0] data;
    bit         par_ok;
    bit         stop;
    int         stop_len;
    logic [7:0] exp_data;
    bit         exp_fe;
    bit         exp_pe;
  } rx_vec_t;

  rx_rec_t rx_q[$];
  int      tx_done_cnt = 0;
  int      checks = 0;
  int      errors = 0;

  always @(negedge clk) begin
    if (rx_done === 1'b1) rx_q.push_back('{rx_data, ferr, perr});
    if (tx_done === 1'b1) tx_done_cnt++;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input int div);
    baud_div = 16'(div);
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  task automatic send(input logic [7:0] w);
    int n = 0;
    bit acc = 1'b0;
    tx_data = w;
    tx_valid = 1'b1;
    while (!acc && n < 3000) begin
      acc = (tx_ready === 1'b1);
      step();
      n++;
    end
    tx_valid = 1'b0;
    chk("tx_accept", int'(acc), 1);
  endtask

  task automatic drive_rx(input logic [7:0] d, input logic pb, input logic sb,
                          input int stop_len, input int bpc);
    rx_drv = 1'b0;
    step(bpc);
    for (int i = 0; i < NB; i++) begin
      rx_drv = d[i];
      step(bpc);
    end
    if (PAR_EN) begin
      rx_drv = pb;
      step(bpc);
    end
    rx_drv = sb;
    step(stop_len);
    rx_drv = 1'b1;
    step(bpc);
  endtask

  task automatic wait_rx(input int want, input int budget);
    int n = 0;
    while (rx_q.size() < want && n < budget) begin
      step();
      n++;
    end
    chk("rx_count", rx_q.size(), want);
  endtask

  task automatic check_words(input string tag, input logic [7:0] exp_w[$]);
    rx_rec_t r;
    for (int i = 0; i < exp_w.size() && rx_q.size() > 0; i++) begin
      r = rx_q.pop_front();
      chk({tag, "_data"}, int'(r.d), int'(exp_w[i]));
      chk({tag, "_ferr"}, int'(r.fe), 0);
      chk({tag, "_perr"}, int'(r.pe), 0);
    end
  endtask

  initial begin
    rx_vec_t    vecs[7];
    logic       exp_bits[$];
    logic [7:0] a5;
    logic [7:0] exp_w[$];
    rx_rec_t    r;
    int         frame_clks;
    int         div;
    int         base;

    vecs[0] = '{8'h55, 1'b1, 1'b0, 40, 8'h55, 1'b1, 1'b0};
    vecs[1] = '{8'hA5, 1'b1, 1'b1, 64, 8'hA5, 1'b0, 1'b0};
    vecs[2] = '{8'h00, 1'b1, 1'b1, 64, 8'h00, 1'b0, 1'b0};
    vecs[3] = '{8'hFF, 1'b1, 1'b1, 64, 8'hFF, 1'b0, 1'b0};
    vecs[4] = '{8'h81, 1'b1, 1'b1, 64, 8'h81, 1'b0, 1'b0};
    vecs[5] = '{8'h07, 1'b0, 1'b1, 64, 8'h07, 1'b0, PAR_EN};
    vecs[6] = '{8'h07, 1'b1, 1'b1, 64, 8'h07, 1'b0, 1'b0};

    // Reset state
    do_reset(3);
    chk("rst_tx", int'(tx), 1);
    chk("rst_ready", int'(tx_ready), 1);
    chk("rst_tx_done", int'(tx_done), 0);
    chk("rst_rx_done", int'(rx_done), 0);
    chk("rst_rx_data", int'(rx_data), 0);
    chk("rst_ferr", int'(ferr), 0);
    chk("rst_perr", int'(perr), 0);

    // TX 0xA5 at divisor 3; accept on a tick edge so the frame is exactly bits*64 clocks
    a5 = 8'hA5;
    exp_bits.push_back(1'b0);
    for (int i = 0; i < NB; i++) exp_bits.push_back(a5[i]);
    if (PAR_EN) exp_bits.push_back(^a5);
    for (int i = 0; i < STOPB; i++) exp_bits.push_back(1'b1);
    frame_clks = exp_bits.size() * OS * 4;
    step(3);
    tx_data = a5;
    tx_valid = 1'b1;
    chk("tx_ready_idle", int'(tx_ready), 1);
    step();
    tx_valid = 1'b0;
    for (int n = 0; n < frame_clks + 8; n++) begin
      chk("tx_line", int'(tx), n < frame_clks ? int'(exp_bits[n / (OS * 4)]) : 1);
      chk("tx_done_time", int'(tx_done), int'(n == frame_clks));
      chk("tx_ready_busy", int'(tx_ready), int'(n >= frame_clks));
      step();
    end

    // RX vector table
    rx_q.delete();
    for (int v = 0; v < 7; v++) begin
      drive_rx(vecs[v].data, vecs[v].par_ok ? ^vecs[v].data : ~^vecs[v].data,
               vecs[v].stop, vecs[v].stop_len, OS * 4);
      wait_rx(1, 200);
      if (rx_q.size() > 0) begin
        r = rx_q.pop_front();
        chk("rxv_data", int'(r.d), int'(vecs[v].exp_data));
        chk("rxv_ferr", int'(r.fe), int'(vecs[v].exp_fe));
        chk("rxv_perr", int'(r.pe), int'(vecs[v].exp_pe));
      end
      rx_q.delete();
    end

    // Short low glitch: no frame, outputs hold, receiver still usable
    rx_drv = 1'b0;
    step(20);
    rx_drv = 1'b1;
    step(200);
    chk("glitch_no_done", rx_q.size(), 0);
    chk("glitch_hold_data", int'(rx_data), 8'h07);
    chk("glitch_hold_ferr", int'(ferr), 0);
    drive_rx(8'h3C, ^8'h3C, 1'b1, OS * 4, OS * 4);
    wait_rx(1, 200);
    if (rx_q.size() > 0) begin
      r = rx_q.pop_front();
      chk("post_glitch_data", int'(r.d), 8'h3C);
      chk("post_glitch_ferr", int'(r.fe), 0);
    end

    // Directed loopback, back-to-back
    loop_en = 1'b1;
    rx_q.delete();
    exp_w = '{8'h00, 8'hFF, 8'h3C};
    foreach (exp_w[i]) send(exp_w[i]);
    wait_rx(3, 2000);
    check_words("loop", exp_w);

    // Random loopback at random divisors
    for (int round = 0; round < 3; round++) begin
      div = int'($urandom_range(0, 4));
      do_reset(div);
      rx_q.delete();
      exp_w.delete();
      for (int k = 0; k < 6; k++) begin
        exp_w.push_back(8'($urandom));
        step(int'($urandom_range(0, 30)));
        send(exp_w[k]);
      end
      wait_rx(6, 3000 * (div + 1));
      check_words("rand", exp_w);
    end

    // Reset during a TX data bit, with i_tx_valid also high: abort, no done pulse
    loop_en = 1'b0;
    do_reset(3);
    send(8'($urandom));
    step(64 + 64 + 20);
    chk("pre_rst_busy", int'(tx_ready), 0);
    rst = 1'b1;
    tx_valid = 1'b1;
    step();
    chk("abort_tx", int'(tx), 1);
    chk("abort_ready", int'(tx_ready), 1);
    chk("abort_done", int'(tx_done), 0);
    rst = 1'b0;
    tx_valid = 1'b0;
    base = tx_done_cnt;
    step(800);
    chk("abort_no_done", tx_done_cnt, base);
    chk("abort_idle_line", int'(tx), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
